taillight_input_conditioner: RTL and testbench



---
 rtl/taillight_input_conditioner.sv | 200 ++++++++++++++++++++
 tb/tb_taillight_input_conditioner.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/taillight_input_conditioner.sv
// taillight_input_conditioner
//
// Turns the raw, asynchronous and bouncing driver controls (turn-signal stalk
// contacts and brake pedal switch) into clean, registered levels for the
// taillight sequencer.
//
// Per input: two-flop synchroniser, then a debouncer that accepts a new level
// only after it has persisted for DEBOUNCE_CYCLES consecutive synchronised
// cycles. The two stalk contacts are then arbitrated by a Moore FSM
// (IDLE / LEFT / RIGHT / FAULT); the brake level is registered once so all
// outputs share the same latency.
//
// Optional feature macro: BRAKE_STRETCH_EN
//   defined   : brake output is held high for at least BRAKE_HOLD cycles.
//   undefined : brake output is the registered debounced brake level only.
//
// Parameters:
//   DEBOUNCE_CYCLES : cycles a new synchronised level must persist (>= 1)
//   BRAKE_HOLD      : minimum brake assertion length, stretch build only (>= 1)
//
// Ports:
//   clk         in  : system clock, rising edge
//   rst_n       in  : asynchronous active-low reset
//   raw_left    in  : stalk left contact (async, bouncing)
//   raw_right   in  : stalk right contact (async, bouncing)
//   raw_brake   in  : brake pedal switch (async, bouncing)
//   turn_left   out : conditioned left-turn request
//   turn_right  out : conditioned right-turn request
//   brake       out : conditioned brake request
//   stalk_fault out : both stalk contacts debounced active

module taillight_input_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned BRAKE_HOLD      = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_left,
    input  logic raw_right,
    input  logic raw_brake,
    output logic turn_left,
    output logic turn_right,
    output logic brake,
    output logic stalk_fault
);

    localparam int unsigned NumCh   = 3;
    localparam int unsigned ChLeft  = 0;
    localparam int unsigned ChRight = 1;
    localparam int unsigned ChBrake = 2;

    localparam int unsigned     CntW    = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

    // Elaboration-time guard on parameter ranges.
    if (DEBOUNCE_CYCLES < 1 || BRAKE_HOLD < 1) begin : g_param_check
        $error("DEBOUNCE_CYCLES and BRAKE_HOLD must both be at least 1");
    end

    // ------------------------------------------------------------------
    // Synchronisers
    // ------------------------------------------------------------------
    logic [NumCh-1:0] raw_vec;
    logic [NumCh-1:0] sync_meta;
    logic [NumCh-1:0] sync_q;

    assign raw_vec = {raw_brake, raw_right, raw_left};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta <= '0;
            sync_q    <= '0;
        end else begin
            sync_meta <= raw_vec;
            sync_q    <= sync_meta;
        end
    end

    // ------------------------------------------------------------------
    // Debouncers: a differing level must be seen on DEBOUNCE_CYCLES
    // consecutive cycles; any return to the held level restarts the count.
    // ------------------------------------------------------------------
    logic [NumCh-1:0] db;
    logic [CntW-1:0]  db_cnt [NumCh];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db <= '0;
            for (int i = 0; i < NumCh; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NumCh; i++) begin
                if (sync_q[i] != db[i]) begin
                    if (db_cnt[i] == CntLast) begin
                        db[i]     <= sync_q[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + 1'b1;
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stalk arbitration FSM
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        StIdle,
        StLeft,
        StRight,
        StFault
    } stalk_state_e;

    stalk_state_e state;
    stalk_state_e state_next;
    logic         db_left;
    logic         db_right;

    assign db_left  = db[ChLeft];
    assign db_right = db[ChRight];

    // Outside FAULT the next state depends only on the contact pair, which
    // gives the direct LEFT<->RIGHT changeover without an IDLE cycle.
    // FAULT is sticky until both contacts are released.
    always_comb begin
        state_next = state;
        unique case (state)
            StIdle, StLeft, StRight: begin
                unique case ({db_left, db_right})
                    2'b10:   state_next = StLeft;
                    2'b01:   state_next = StRight;
                    2'b11:   state_next = StFault;
                    default: state_next = StIdle;
                endcase
            end
            StFault: begin
                if (!db_left && !db_right) begin
                    state_next = StIdle;
                end
            end
            default: state_next = StIdle;
        endcase
    end

    // Outputs are decoded from the next state so they are registered
    // alongside the state itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= StIdle;
            turn_left   <= 1'b0;
            turn_right  <= 1'b0;
            stalk_fault <= 1'b0;
        end else begin
            state       <= state_next;
            turn_left   <= (state_next == StLeft);
            turn_right  <= (state_next == StRight);
            stalk_fault <= (state_next == StFault);
        end
    end

    // ------------------------------------------------------------------
    // Brake output
    // ------------------------------------------------------------------
`ifdef BRAKE_STRETCH_EN
    localparam int unsigned      HoldW    = $clog2(BRAKE_HOLD) + 1;
    localparam logic [HoldW-1:0] HoldLoad = HoldW'(BRAKE_HOLD - 1);

    logic [HoldW-1:0] hold_cnt;

    // hold_cnt is loaded on the edge where brake rises; brake stays high
    // while either the debounced level or the remaining hold is active.
    // A re-press during the hold does not reload, as brake never fell.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            brake    <= 1'b0;
            hold_cnt <= '0;
        end else begin
            brake <= db[ChBrake] | (hold_cnt != '0);
            if (db[ChBrake] && !brake) begin
                hold_cnt <= HoldLoad;
            end else if (hold_cnt != '0) begin
                hold_cnt <= hold_cnt - 1'b1;
            end
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            brake <= 1'b0;
        end else begin
            brake <= db[ChBrake];
        end
    end
`endif

endmodule

// File: tb/tb_taillight_input_conditioner.sv
// Self-checking bench for taillight_input_conditioner: directed scenarios
// with literal expectations, then randomized contact activity compared
// every cycle against a behavioural model.

module tb_taillight_input_conditioner;

    localparam int unsigned D = 4;
    localparam int unsigned H = 8;

    logic       clk;
    logic       rst_n;
    logic [2:0] raw;   // {brake, right, left}
    logic       turn_left;
    logic       turn_right;
    logic       brake;
    logic       stalk_fault;

    int n_total = 0;
    int n_pass  = 0;

    taillight_input_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .BRAKE_HOLD     (H)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .raw_left   (raw[0]),
        .raw_right  (raw[1]),
        .raw_brake  (raw[2]),
        .turn_left  (turn_left),
        .turn_right (turn_right),
        .brake      (brake),
        .stalk_fault(stalk_fault)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Output vector bit order: {stalk_fault, brake, turn_right, turn_left}
    logic [3:0] dut_vec;
    assign dut_vec = {stalk_fault, brake, turn_right, turn_left};

    // ------------------------------------------------------------------
    // Behavioural model
    //   raw samples are kept as a history; the synchroniser is a 2-sample
    //   delay; a channel's debounced level flips once its last D
    //   synchronised samples all disagree with it; the stalk pair maps to
    //   a request except that FAULT holds until both are released.
    // ------------------------------------------------------------------
    bit [15:0] hist [3];
    bit [2:0]  m_db;
    int        m_st;      // 0 idle, 1 left, 2 right, 3 fault
    bit        m_brake;
`ifdef BRAKE_STRETCH_EN
    int        m_since;   // edges since brake output last rose
`endif

    logic [3:0] exp_vec;
    assign exp_vec = {m_st == 3, m_brake, m_st == 2, m_st == 1};

    task automatic model_reset();
        for (int c = 0; c < 3; c++) hist[c] = '0;
        m_db    = '0;
        m_st    = 0;
        m_brake = 1'b0;
`ifdef BRAKE_STRETCH_EN
        m_since = H;
`endif
    endtask

    task automatic model_step();
        bit l, r, b, nb, all_diff;
        l = m_db[0];
        r = m_db[1];
        b = m_db[2];
        if (m_st == 3) begin
            if (!l && !r) m_st = 0;
        end else begin
            m_st = (l && r) ? 3 : (l ? 1 : (r ? 2 : 0));
        end
`ifdef BRAKE_STRETCH_EN
        if (m_since < H) m_since++;
        nb = b || (m_since < H);
        if (nb && !m_brake) m_since = 0;
        m_brake = nb;
`else
        nb = b;
        m_brake = nb;
`endif
        for (int c = 0; c < 3; c++) begin
            // hist[c][k] is the raw sample k+1 edges ago; synchronised value
            // seen now is hist[c][1].
            all_diff = 1'b1;
            for (int k = 1; k <= D; k++) begin
                if (hist[c][k] == m_db[c]) all_diff = 1'b0;
            end
            if (all_diff) m_db[c] = ~m_db[c];
            hist[c] = {hist[c][14:0], raw[c]};
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_step();
        end
    end

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            check("model_cycle", 32'(dut_vec), 32'(exp_vec));
            check("turn_exclusive", 32'(turn_left & turn_right), 32'd0);
        end
    end

    task automatic wait_edges(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive a clean pulse of len cycles on channel ch and count how many
    // cycles the matching output is high.
    task automatic count_pulse(input int ch, input int len, output int cnt);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i == 0)   raw[ch] = 1'b1;
            if (i == len) raw[ch] = 1'b0;
            @(posedge clk);
            #1;
            if (dut_vec[ch]) cnt++;
        end
    endtask

    int cnt;
    int run [3];

    initial begin
        rst_n = 1'b0;
        raw   = 3'b111;

        // Reset with all inputs active, then latency on release.
        wait_edges(3);
        check("reset_outputs", 32'(dut_vec), 32'h0);
        @(negedge clk);
        raw   = 3'b101;
        rst_n = 1'b1;
        wait_edges(6);
        check("latency_edge6_left", 32'(turn_left), 32'd0);
        check("latency_edge6_brake", 32'(brake), 32'd0);
        wait_edges(1);
        check("latency_edge7_left", 32'(turn_left), 32'd1);
        check("latency_edge7_brake", 32'(brake), 32'd1);
        @(negedge clk);
        raw = 3'b000;
        wait_edges(20);

        // Glitch rejection.
        count_pulse(0, 3, cnt);
        check("glitch_3cyc", 32'(cnt), 32'd0);
        count_pulse(0, 4, cnt);
        check("pulse_4cyc", 32'(cnt), 32'd4);

        // Changeover left -> right.
        @(negedge clk);
        raw = 3'b001;
        wait_edges(15);
        check("hold_left", 32'(dut_vec), 32'h1);
        @(negedge clk);
        raw = 3'b010;
        wait_edges(6);
        check("changeover_edge6", 32'(dut_vec), 32'h1);
        wait_edges(1);
        check("changeover_edge7", 32'(dut_vec), 32'h2);
        @(negedge clk);
        raw = 3'b000;
        wait_edges(15);

        // Fault, sticky until full release.
        @(negedge clk);
        raw = 3'b011;
        wait_edges(15);
        check("fault_both", 32'(dut_vec), 32'h8);
        @(negedge clk);
        raw = 3'b001;
        wait_edges(15);
        check("fault_sticky", 32'(dut_vec), 32'h8);
        @(negedge clk);
        raw = 3'b000;
        wait_edges(6);
        check("fault_release_edge6", 32'(dut_vec), 32'h8);
        wait_edges(1);
        check("fault_release_edge7", 32'(dut_vec), 32'h0);
        wait_edges(10);

        // Brake stretch.
        count_pulse(2, 5, cnt);
`ifdef BRAKE_STRETCH_EN
        check("brake_short", 32'(cnt), 32'd8);
`else
        check("brake_short", 32'(cnt), 32'd5);
`endif
        count_pulse(2, 12, cnt);
        check("brake_long", 32'(cnt), 32'd12);

        // Asynchronous reset in LEFT.
        @(negedge clk);
        raw = 3'b001;
        wait_edges(15);
        check("pre_reset_left", 32'(dut_vec), 32'h1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_clear", 32'(dut_vec), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_edges(6);
        check("post_reset_edge6", 32'(dut_vec), 32'h0);
        wait_edges(1);
        check("post_reset_edge7", 32'(dut_vec), 32'h1);
        @(negedge clk);
        raw = 3'b000;
        wait_edges(15);

        // Randomized contact activity with occasional resets.
        for (int c = 0; c < 3; c++) run[c] = $urandom_range(1, 12);
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            for (int c = 0; c < 3; c++) begin
                if (run[c] == 0) begin
                    raw[c] = ~raw[c];
                    run[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3)
                                                         : $urandom_range(4, 16);
                end
                run[c]--;
            end
            if ($urandom_range(0, 499) == 0) begin
                #2 rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
        end
        wait_edges(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
